// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign-fix cycle before the result.
//   state  | meaning
//   IDLE   | waiting for start
//   CALC   | WIDTH iterations of shift-add / restoring subtract
//   FIX    | sign correction and result select
//   DONE   | result valid, done pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic               neg_q, neg_d, negr_q, negr_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               accept, is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_neg;

    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_div   = funct3[2];
    assign sgn_a    = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    assign sgn_b    = sgn_a && (funct3 != 3'd2);
    assign neg_a    = sgn_a & op_a[WIDTH-1];
    assign neg_b    = sgn_b & op_b[WIDTH-1];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = sgn_b && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);

    // Multiply: acc = {partial_hi, remaining multiplier}. Divide: acc = {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign acc_neg   = -acc_q;
    assign quo_fix   = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_CALC: begin
                if (f3_q[2]) begin
                    acc_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                            : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                case (f3_q)
                    3'd0:             result_d = neg_q ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    3'd1, 3'd2, 3'd3: result_d = neg_q ? acc_neg[2*WIDTH-1:WIDTH]
                                                       : acc_q[2*WIDTH-1:WIDTH];
                    3'd4, 3'd5:       result_d = quo_fix;
                    default:          result_d = rem_fix;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        if (accept) begin
            f3_d   = funct3;
            cnt_d  = '0;
            neg_d  = neg_a ^ neg_b;
            negr_d = neg_a;
            opnd_d = is_div ? mag_b : mag_a;
            acc_d  = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            // Divide-by-zero and signed overflow have fixed answers; skip the iteration.
            if (is_div && (div_zero || div_ovf)) begin
                state_d  = S_DONE;
                result_d = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
            end else begin
                state_d = S_CALC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with cycle-level timing windows,
// checked every cycle, plus directed operations with hand-computed results.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && (b == 32'd0 ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // cyc = index of the cycle following the most recent rising edge.
    int          cyc = 0;
    int          m_lo = 0;
    int          m_hi = -1;
    int          m_done = -1;
    logic [31:0] m_new = 32'd0;
    logic [31:0] m_held = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= 0;
            m_lo   <= 0;
            m_hi   <= -1;
            m_done <= -1;
            m_new  <= 32'd0;
            m_held <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (cyc == m_done) m_held <= m_new;
            if (start && !(cyc >= m_lo && cyc <= m_hi)) begin
                m_new <= ref_op(funct3, op_a, op_b);
                if (is_special(funct3, op_a, op_b)) begin
                    m_lo   <= 0;
                    m_hi   <= -1;
                    m_done <= cyc + 1;
                end else begin
                    m_lo   <= cyc + 1;
                    m_hi   <= cyc + 33;
                    m_done <= cyc + 34;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(cyc >= m_lo && cyc <= m_hi));
            chk("done", 32'(done), 32'(cyc == m_done));
            chk("result", result, (cyc == m_done) ? m_new : m_held);
        end
    endtask

    // Issues one op; poke>0 pulses a stray start at that many cycles after acceptance.
    task automatic op(input string nm, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat,
                      input bit now, input int poke);
        int n, nb;
        bit seen;
        if (!now) @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        funct3 = 3'($urandom_range(7, 0));
        op_a = $urandom;
        op_b = $urandom;
        n = 1; nb = 0; seen = 1'b0;
        while (!seen && n <= 40) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                start = (n == poke);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
        chk({nm, "_value"}, result, exp);
    endtask

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        fork
            compare_loop();
        join_none

        op("mul_7x8", 3'd0, 32'd7, 32'd8, 32'h38, 34, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("mul_hold", result, 32'h38);

        op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0, 0);
        op("mulh_m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0, 0);
        op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0, 0);
        op("mul_neg",  3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34, 1'b0, 0);

        op("div_13_6",  3'd4, 32'd13, 32'd6, 32'd2, 34, 1'b0, 0);
        op("rem_13_6",  3'd6, 32'd13, 32'd6, 32'd1, 34, 1'b0, 0);
        op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, 0);
        op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, 0);
        op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 1'b0, 0);
        op("div_7_m2",  3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0, 0);
        op("rem_7_m2",  3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0, 0);

        op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
        op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b0, 0);
        op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 0);
        op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);

        op("mul_ignore_start", 3'd0, 32'd7, 32'd8, 32'h38, 34, 1'b0, 10);

        op("b2b_first",  3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 34, 1'b0, 0);
        op("b2b_second", 3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1, 0);
        op("b2b_special", 3'd7, 32'd9, 32'd0, 32'd9, 1, 1'b1, 0);

        // Abort a divide mid-flight with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        op("post_reset_div", 3'd4, 32'd100, 32'd7, 32'd14, 34, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file. It consumes the two read-data operands (RD1 → op_a, RD2 → op_b) plus funct3, computes over multiple cycles, and returns a 32-bit result for write-back via WD3. A start/busy/done handshake lets the control path stall the single-cycle core until the result is ready.

Parameters:
WIDTH, 32, operand/result width; also the iteration count of the CALC state

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a  input  WIDTH  rs1 operand (register-file RD1)
op_b  input  WIDTH  rs2 operand (register-file RD2)
busy  output  1  high while an operation is in progress (CALC, FIX)
done  output  1  one-cycle pulse: result valid
result  output  WIDTH  result; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0; all internal accumulators cleared. Reset mid-operation aborts it and produces no done pulse.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE. funct3, op_a, and op_b are latched at that edge. Later input changes have no effect.
- start while busy=1 is ignored; it is not queued.
- Normal path: accept edge E0 → CALC. CALC lasts WIDTH edges, with one bit per edge and an internal counter 0..WIDTH-1. → FIX (1 edge) → DONE.
  - done=1 and result valid in the cycle after edge E0+WIDTH+1 (34 cycles for WIDTH=32).
  - DONE → IDLE on the next edge unless a new start is accepted there.
- Multiply: unsigned shift-add on operand magnitudes, producing a 2*WIDTH product.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - FIX applies two's-complement negation of the 2*WIDTH product when the operand signs differ (signed operands only).
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide: restoring division on magnitudes.
  - Signed ops (DIV/REM) take absolute values. FIX negates the quotient if the signs differ and negates the remainder if the dividend is negative.
  - The remainder takes the sign of the dividend; the quotient truncates toward zero.
- Special cases bypass CALC/FIX: accept edge E0 → DONE directly, so done=1 in the cycle after E0.
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- busy=1 exactly in CALC and FIX. done=1 exactly in DONE. busy and done are never high together.
- No exceptions or flags are generated; all results follow the RISC-V M-extension definition.

Test Plan:
- Reset then MUL, op_a=7, op_b=8 → busy high for 33 cycles; done pulses 34 cycles after start; result=0x00000038; result still 0x38 five cycles later.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 13/6 → 2; REM 13/6 → 1. DIV 0xFFFFFFF9/2 (-7/2) → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Each case gives done in the cycle after start with busy never asserted.
- Pulse start again at cycle 10 of a MUL → ignored; original result unchanged. Start asserted during the DONE cycle → accepted; the back-to-back op completes 34 cycles later.
- Drive rst_n low at cycle 15 of a DIV → busy=0, done=0, result=0 immediately with no clock edge; no done pulse follows. A new op after reset release completes correctly.
